// File: rtl/core_pkg.sv
// Shared constants and types for the integer core register file.
package core_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ZERO      = 0;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0]          xlen_t;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: x0 forcing, writeback bypass, busy qualification.
module regfile_sb_rdport
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy_q,
  input  logic                        wb_valid,
  input  logic [AW-1:0]               wb_rd,
  input  logic [XLEN-1:0]             wb_data,
  output logic [XLEN-1:0]             data,
  output logic                        busy
);

  logic is_zero;
  logic wb_hit;

  assign is_zero = (addr == AW'(REG_ZERO));
  assign wb_hit  = wb_valid && (wb_rd == addr);

  always_comb begin
    if (is_zero) begin
      data = '0;
    end else if (wb_hit) begin
      data = wb_data;
    end else begin
      data = regs[addr];
    end
  end

  // A producer writing back this cycle makes the operand ready right now.
  assign busy = !is_zero && busy_q[addr] && !wb_hit;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and a per-register
// busy scoreboard used by the hazard unit.
module regfile_sb
  import core_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy_q;
  logic [NREGS-1:0]           busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (wb_valid && (wb_rd != AW'(REG_ZERO))) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Issue beats a same-cycle writeback: the new producer supersedes the old.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_valid && (iss_rd == AW'(r)) && !flush) begin
        busy_d[r] = 1'b1;
      end else if (flush) begin
        busy_d[r] = 1'b0;
      end else if (wb_valid && (wb_rd == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rdport (
      .addr     (rd_addr[i*AW +: AW]),
      .regs     (regs_q),
      .busy_q   (busy_q),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .data     (rd_data[i*XLEN +: XLEN]),
      .busy     (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (32x32, two read ports).
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        chk;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_busy;
    logic [31:0] e_bv;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mk(logic r, logic iv, logic [4:0] ir, logic wv, logic [4:0] wr,
                              logic [31:0] wd, logic fl, logic [4:0] a0, logic [4:0] a1,
                              logic ck, logic [31:0] d0, logic [31:0] d1, logic [1:0] bz,
                              logic [31:0] bv);
    vec_t v;
    v.rst_n = r;  v.iss_v = iv; v.iss_rd = ir; v.wb_v = wv; v.wb_rd = wr; v.wb_data = wd;
    v.flush = fl; v.a0 = a0; v.a1 = a1; v.chk = ck;
    v.e_d0 = d0; v.e_d1 = d1; v.e_busy = bz; v.e_bv = bv;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n     = v.rst_n;
    iss_valid = v.iss_v;
    iss_rd    = v.iss_rd;
    wb_valid  = v.wb_v;
    wb_rd     = v.wb_rd;
    wb_data   = v.wb_data;
    flush     = v.flush;
    rd_addr   = {v.a1, v.a0};
  endtask

  initial begin
    vec_t idle;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);

    //          rst iv ir wv wr  wdata         fl a0 a1 ck d0            d1            bz     bv
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 1, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0,31,15, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 2, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h12345678, 0, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 5, 1, 0,            32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 7, 32'h11,       0, 1, 2, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 7, 32'h22,       0, 5, 7, 1, 32'hDEADBEEF, 32'h22,       2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 7, 7, 1, 32'h22,       32'h22,       2'b00, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0, 32'h0,        0, 3, 3, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 3, 1, 1, 0,            0,            2'b01, 32'h8));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 3, 1, 1, 0,            0,            2'b01, 32'h8));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 1, 3, 1, 0,            0,            2'b10, 32'h8));
    vecs.push_back(mk(1, 0, 0, 1, 3, 32'h33,       0, 3, 3, 1, 32'h33,       32'h33,       2'b00, 32'h8));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 3, 3, 1, 32'h33,       32'h33,       2'b00, 0));
    vecs.push_back(mk(1, 1, 9, 0, 0, 32'h0,        0, 9, 9, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 1, 9, 1, 9, 32'hAA,       0, 9, 1, 1, 32'hAA,       0,            2'b00, 32'h200));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 9, 0, 1, 32'hAA,       0,            2'b01, 32'h200));
    vecs.push_back(mk(1, 1, 2, 0, 0, 32'h0,        0, 9, 9, 1, 32'hAA,       32'hAA,       2'b11, 32'h200));
    vecs.push_back(mk(1, 1, 4, 0, 0, 32'h0,        0, 2, 9, 1, 0,            32'hAA,       2'b11, 32'h204));
    vecs.push_back(mk(1, 1, 6, 1, 4, 32'h55,       1, 4, 2, 1, 32'h55,       0,            2'b10, 32'h214));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 4, 6, 1, 32'h55,       0,            2'b00, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 0, 1, 1, 0,            0,            2'b00, 0));
    vecs.push_back(mk(1, 1, 8, 0, 0, 32'h0,        0, 7, 5, 1, 32'h22,       32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8, 32'h99,       0, 8, 8, 1, 32'h99,       32'h99,       2'b00, 32'h100));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 8, 7, 1, 0,            0,            2'b00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d rd_data0", i), rd_data[31:0],  vecs[i].e_d0);
        check($sformatf("row%0d rd_data1", i), rd_data[63:32], vecs[i].e_d1);
        check($sformatf("row%0d rd_busy", i),  {30'b0, rd_busy}, {30'b0, vecs[i].e_busy});
        check($sformatf("row%0d busy_vec", i), busy_vec,       vecs[i].e_bv);
      end
    end

    // Issue latency: busy_vec follows the issuing edge by exactly one edge.
    @(negedge clk);
    drive(idle);
    iss_valid = 1'b1; iss_rd = 5'd12; rd_addr = {5'd0, 5'd12};
    #1;
    check("lat pre-edge busy_vec", busy_vec, 32'h0);
    check("lat pre-edge rd_busy", {30'b0, rd_busy}, 32'h0);
    @(posedge clk);
    #1;
    check("lat post-edge busy_vec", busy_vec, 32'h1000);
    check("lat post-edge rd_busy", {30'b0, rd_busy}, 32'h1);

    // Flush with a same-cycle writeback: data lands, scoreboard clears, issue dropped.
    @(negedge clk);
    drive(idle);
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h77;
    iss_valid = 1'b1; iss_rd = 5'd13; rd_addr = {5'd13, 5'd12};
    @(negedge clk);
    drive(idle);
    rd_addr = {5'd13, 5'd12};
    #1;
    check("flush r12 data", rd_data[31:0], 32'h77);
    check("flush busy_vec", busy_vec, 32'h0);
    check("flush rd_busy", {30'b0, rd_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
